// File: rtl/user_clk_switch_pkg.sv
// user_clk_switch_pkg: FSM states and helpers shared by the clock switch controller
package user_clk_switch_pkg;
  typedef enum logic [1:0] {IDLE, DEAD, SETTLE, RESTORE} state_t;
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction
endpackage

// File: rtl/user_clk_switch_timer.sv
// user_clk_switch_timer: loadable 8-bit down-counter that stops at zero
module user_clk_switch_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!zero) cnt <= cnt - 8'd1;
  assign zero = cnt == '0;
endmodule

// File: rtl/user_clk_switch_ctrl.sv
// user_clk_switch_ctrl: glitch-free BUFGCE-bank select with dead time, settle time and failover
module user_clk_switch_ctrl
  import user_clk_switch_pkg::*;
#(
  parameter  int N_CLK         = 4,
  parameter  int DEAD_CYCLES   = 8,
  parameter  int SETTLE_CYCLES = 4,
  parameter  int INIT_SEL      = 0,
  parameter  int FAILOVER      = 1,
  localparam int SELW          = sel_width(N_CLK)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             sel_valid,
  output logic             sel_ready,
  input  logic [SELW-1:0]  sel_idx,
  input  logic [N_CLK-1:0] clk_ok,
  output logic [N_CLK-1:0] ce,
  output logic [SELW-1:0]  active_sel,
  output logic             busy,
  output logic             switch_done,
  output logic             sel_error,
  output logic             clk_lost
);
  localparam logic [7:0] DEAD_LD   = 8'(DEAD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [N_CLK-1:0] CE_INIT = N_CLK'(onehot(4'(INIT_SEL)));
  state_t state, state_n;
  logic [N_CLK-1:0] ce_n, ok_q;
  logic [SELW-1:0] tgt, tgt_n, act_n, low;
  logic [15:0] ok_pad, okq_pad;
  logic done_n, err_n, req_ok, lost, fail_go, t_load, t_zero;
  logic [7:0] t_val;
  assign ok_pad    = 16'(clk_ok);
  assign okq_pad   = 16'(ok_q);
  assign req_ok    = (int'(sel_idx) < N_CLK) && ok_pad[4'(sel_idx)];
  assign lost      = (state == IDLE) && okq_pad[4'(active_sel)] && !ok_pad[4'(active_sel)];
  assign fail_go   = (FAILOVER != 0) && lost && (|clk_ok);
  assign sel_ready = (state == IDLE) && !fail_go;
  assign busy      = state != IDLE;
  always_comb begin
    low = '0;
    for (int i = N_CLK - 1; i >= 0; i--) if (clk_ok[i]) low = SELW'(i);
  end
  always_comb begin
    state_n = state;
    ce_n    = ce;
    act_n   = active_sel;
    tgt_n   = tgt;
    done_n  = 1'b0;
    err_n   = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
    case (state)
      IDLE:
        if (fail_go) begin
          state_n = DEAD;
          ce_n    = '0;
          tgt_n   = low;
          t_load  = 1'b1;
          t_val   = DEAD_LD;
        end else if (sel_valid) begin
          if (!req_ok) err_n = 1'b1;
          else if (sel_idx == active_sel) done_n = 1'b1;
          else begin
            state_n = DEAD;
            ce_n    = '0;
            tgt_n   = sel_idx;
            t_load  = 1'b1;
            t_val   = DEAD_LD;
          end
        end
      DEAD:
        // losing the target before it is enabled falls back to the old clock
        if (!ok_pad[4'(tgt)]) begin
          state_n = RESTORE;
          ce_n    = N_CLK'(onehot(4'(active_sel)));
          t_load  = 1'b1;
          t_val   = SETTLE_LD;
        end else if (t_zero) begin
          state_n = SETTLE;
          ce_n    = N_CLK'(onehot(4'(tgt)));
          act_n   = tgt;
          t_load  = 1'b1;
          t_val   = SETTLE_LD;
        end
      SETTLE:
        if (t_zero) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      RESTORE:
        if (t_zero) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
    endcase
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state       <= IDLE;
      ce          <= CE_INIT;
      active_sel  <= SELW'(INIT_SEL);
      tgt         <= SELW'(INIT_SEL);
      ok_q        <= '0;
      switch_done <= 1'b0;
      sel_error   <= 1'b0;
      clk_lost    <= 1'b0;
    end else begin
      state       <= state_n;
      ce          <= ce_n;
      active_sel  <= act_n;
      tgt         <= tgt_n;
      ok_q        <= clk_ok;
      switch_done <= done_n;
      sel_error   <= err_n;
      clk_lost    <= lost;
    end
  user_clk_switch_timer u_timer (
    .clk      (aclk),
    .rst      (areset),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );
endmodule
